// File: rtl/ap_mult_pkg.sv
// Shared types, widths and small helpers for the iterative approximate 8x8 multiplier.
package ap_mult_pkg;

  localparam int NIB_W  = 4;
  localparam int PROD_W = 8;
  localparam int ACC_W  = 17;
  localparam int RES_W  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // step[1] selects the b nibble, step[0] the a nibble; weight is 4*(i+j).
  function automatic logic [3:0] nib_shift(input logic [1:0] step);
    return {step[1] & step[0], step[1] ^ step[0], 2'b00};
  endfunction

  function automatic logic [1:0] half_add(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

  function automatic logic [1:0] full_add(input logic x, input logic y, input logic z);
    return {(x & y) | (z & (x ^ y)), x ^ y ^ z};
  endfunction

endpackage

// File: rtl/ap_mult4_core.sv
// 4x4 approximate multiplier: AND-array partial products reduced by a Wallace-style
// compressor whose weight-8 column uses OR-based half adders (biased high when both inputs set).
module ap_mult4_ppcom
  import ap_mult_pkg::*;
(
  input  logic [15:0]       pp,
  output logic [PROD_W-1:0] res
);

  logic s1, k1, s2, k2, s4, k4, s5, k5;
  logic s3a, k3a, s3b, k3b;
  logic t3, m3, t4, m4;
  logic [PROD_W-1:0] row_a, row_b, row_c;

  // First layer: column heights 1,2,3,4,3,2,1.
  assign {k1, s1} = half_add(pp[1], pp[4]);
  assign {k2, s2} = full_add(pp[2], pp[5], pp[8]);
  assign {k4, s4} = full_add(pp[7], pp[10], pp[13]);
  assign {k5, s5} = half_add(pp[11], pp[14]);

  // Approximate pair compressors: value a+b+(a&b) instead of a+b.
  assign s3a = pp[3] | pp[6];
  assign k3a = pp[3] & pp[6];
  assign s3b = pp[9] | pp[12];
  assign k3b = pp[9] & pp[12];

  // Second layer on the two tallest columns.
  assign {m3, t3} = full_add(s3a, s3b, k2);
  assign {m4, t4} = full_add(s4, k3a, k3b);

  assign row_a = {1'b0, pp[15], s5, t4, t3, s2, s1, pp[0]};
  assign row_b = {1'b0, k5, k4, m3, 1'b0, k1, 2'b00};
  assign row_c = {2'b00, m4, 5'b00000};

  // Largest reachable value is 241, so the 8-bit final add never wraps.
  assign res = row_a + row_b + row_c;

endmodule

module ap_mult4_core
  import ap_mult_pkg::*;
(
  input  logic [NIB_W-1:0]  a,
  input  logic [NIB_W-1:0]  b,
  output logic [PROD_W-1:0] res
);

  logic [15:0] pp;

  for (genvar r = 0; r < NIB_W; r++) begin : g_row
    for (genvar c = 0; c < NIB_W; c++) begin : g_col
      assign pp[NIB_W*r + c] = a[c] & b[r];
    end
  end

  ap_mult4_ppcom u_ppcom (
    .pp  (pp),
    .res (res)
  );

endmodule

// File: rtl/ap_mult8_seq.sv
// Iterative 8x8 approximate multiplier: one 4x4 core reused across nibble pairs,
// shift-accumulated into a 17-bit sum, with valid/ready on both sides.
//
//   state | meaning
//   IDLE  | in_ready high, waiting for operands
//   CALC  | one nibble product accumulated per cycle, step 0..3
//   DONE  | out_valid high, result held until consumer accepts
module ap_mult8_seq
  import ap_mult_pkg::*;
#(
  parameter bit TRUNC_LL = 1'b0,
  parameter bit SAT_EN   = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       a_i,
  input  logic [7:0]       b_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] res_o,
  output logic             ovf_o
);

  state_e             state_q, state_d;
  logic [7:0]         a_q, a_d;
  logic [7:0]         b_q, b_d;
  logic [1:0]         step_q, step_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   pp_ext;
  logic [NIB_W-1:0]   a_nib, b_nib;
  logic [PROD_W-1:0]  core_p;

  assign a_nib = step_q[0] ? a_q[7:4] : a_q[3:0];
  assign b_nib = step_q[1] ? b_q[7:4] : b_q[3:0];

  ap_mult4_core u_core (
    .a   (a_nib),
    .b   (b_nib),
    .res (core_p)
  );

  assign pp_ext = {{(ACC_W-PROD_W){1'b0}}, core_p} << nib_shift(step_q);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    step_d  = step_q;
    acc_d   = acc_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a_i;
          b_d     = b_i;
          acc_d   = '0;
          step_d  = TRUNC_LL ? 2'd1 : 2'd0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d  = acc_q + pp_ext;
        step_d = step_q + 2'd1;
        if (step_q == 2'd3) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      step_q  <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      step_q  <= step_d;
      acc_q   <= acc_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);

  // acc is frozen in DONE, so these stay stable while the consumer stalls.
  assign ovf_o = acc_q[ACC_W-1];
  assign res_o = (SAT_EN && acc_q[ACC_W-1]) ? {RES_W{1'b1}} : acc_q[RES_W-1:0];

endmodule

// File: tb/tb_ap_mult8_seq.sv
// Scoreboard bench for ap_mult8_seq: three instances cover default, SAT_EN=0 and TRUNC_LL=1.
module tb_ap_mult8_seq;

  typedef struct packed {
    logic [15:0] res;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        iv_tr = 1'b0;
  logic        out_ready = 1'b0;
  logic [7:0]  a = 8'h00;
  logic [7:0]  b = 8'h00;

  logic        rdy, ov, ovf;
  logic [15:0] res;
  logic        rdy_ns, ov_ns, ovf_ns;
  logic [15:0] res_ns;
  logic        rdy_tr, ov_tr, ovf_tr;
  logic [15:0] res_tr;

  int checks = 0;
  int failures = 0;

  exp_t q_sat[$];
  exp_t q_ns[$];
  exp_t q_tr[$];

  always #5 clk = ~clk;

  ap_mult8_seq #(.TRUNC_LL(1'b0), .SAT_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy), .a_i(a), .b_i(b),
    .out_valid(ov), .out_ready(out_ready), .res_o(res), .ovf_o(ovf)
  );

  ap_mult8_seq #(.TRUNC_LL(1'b0), .SAT_EN(1'b0)) dut_ns (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_ns), .a_i(a), .b_i(b),
    .out_valid(ov_ns), .out_ready(out_ready), .res_o(res_ns), .ovf_o(ovf_ns)
  );

  ap_mult8_seq #(.TRUNC_LL(1'b1), .SAT_EN(1'b1)) dut_tr (
    .clk(clk), .rst(rst), .in_valid(iv_tr), .in_ready(rdy_tr), .a_i(a), .b_i(b),
    .out_valid(ov_tr), .out_ready(out_ready), .res_o(res_tr), .ovf_o(ovf_tr)
  );

  // Core model: exact product plus 8 for each weight-8 pair that is fully set.
  function automatic int bt(input int v, input int k);
    return (v >> k) & 1;
  endfunction

  function automatic int core_m(input int x, input int y);
    return x * y + 8 * (bt(x,3) * bt(x,2) * bt(y,0) * bt(y,1)
                      + bt(x,1) * bt(x,0) * bt(y,2) * bt(y,3));
  endfunction

  function automatic exp_t model(input int x, input int y, input bit trunc, input bit sat);
    int          s;
    logic [16:0] accv;
    exp_t        e;
    s = 0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        if (!(trunc && i == 0 && j == 0))
          s += core_m((x >> (4*j)) & 15, (y >> (4*i)) & 15) << (4*(i+j));
    accv  = 17'(s);
    e.ovf = accv[16];
    e.res = (sat && accv[16]) ? 16'hFFFF : accv[15:0];
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_main(input logic [7:0] x, input logic [7:0] y);
    q_sat.push_back(model(x, y, 1'b0, 1'b1));
    q_ns.push_back(model(x, y, 1'b0, 1'b0));
  endtask

  task automatic send(input logic [7:0] x, input logic [7:0] y);
    a = x;
    b = y;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input bit tr, output int lat);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if ((tr ? ov_tr : ov) === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    #2 rst = 1'b1;
    repeat (3) tick();
    checks++;
    if (rdy !== 1'b1 || ov !== 1'b0) begin
      failures++;
      $display("FAIL reset_handshake: in_ready=%b out_valid=%b, want 1 0", rdy, ov);
    end
    checks++;
    if (res !== 16'h0000 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: res=%h ovf=%b, want 0000 0", res, ovf);
    end
    checks++;
    if (rdy_ns !== 1'b1 || rdy_tr !== 1'b1 || ov_ns !== 1'b0 || ov_tr !== 1'b0) begin
      failures++;
      $display("FAIL reset_variants: rdy_ns=%b rdy_tr=%b ov_ns=%b ov_tr=%b, want 1 1 0 0",
               rdy_ns, rdy_tr, ov_ns, ov_tr);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (rdy !== 1'b1 || ov !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b, want 1 0", rdy, ov);
    end
  endtask

  task automatic test_basic();
    exp_t e, en;
    int   lat;
    out_ready = 1'b1;
    q_sat.push_back('{16'h0001, 1'b0});
    q_ns.push_back('{16'h0001, 1'b0});
    send(8'h01, 8'h01);
    wait_out(1'b0, lat);
    checks++;
    if (lat != 4) begin
      failures++;
      $display("FAIL basic_latency: got %0d cycles, want 4", lat);
    end
    e  = q_sat.pop_front();
    en = q_ns.pop_front();
    checks++;
    if (res !== e.res || ovf !== e.ovf) begin
      failures++;
      $display("FAIL basic_res: got %h/%b, want %h/%b", res, ovf, e.res, e.ovf);
    end
    checks++;
    if (res_ns !== en.res || ovf_ns !== en.ovf) begin
      failures++;
      $display("FAIL basic_res_nosat: got %h/%b, want %h/%b", res_ns, ovf_ns, en.res, en.ovf);
    end
    tick();
    checks++;
    if (ov !== 1'b0 || rdy !== 1'b1) begin
      failures++;
      $display("FAIL basic_return_idle: out_valid=%b in_ready=%b, want 0 1", ov, rdy);
    end
  endtask

  task automatic test_trunc();
    logic [7:0] va[3];
    logic [7:0] vb[3];
    exp_t       e;
    int         lat;
    va = '{8'h10, 8'h00, 8'hFF};
    vb = '{8'h10, 8'hFF, 8'hFF};
    q_tr.push_back('{16'h0100, 1'b0});
    q_tr.push_back('{16'h0000, 1'b0});
    q_tr.push_back('{16'hFFFF, 1'b1});
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a = va[k];
      b = vb[k];
      iv_tr = 1'b1;
      tick();
      iv_tr = 1'b0;
      wait_out(1'b1, lat);
      checks++;
      if (lat != 3) begin
        failures++;
        $display("FAIL trunc_latency[%0d]: got %0d cycles, want 3", k, lat);
      end
      e = q_tr.pop_front();
      checks++;
      if (res_tr !== e.res || ovf_tr !== e.ovf) begin
        failures++;
        $display("FAIL trunc_res[%0d]: got %h/%b, want %h/%b", k, res_tr, ovf_tr, e.res, e.ovf);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    exp_t e, en;
    int   lat;
    out_ready = 1'b0;
    push_main(8'h12, 8'h34);
    send(8'h12, 8'h34);
    wait_out(1'b0, lat);
    checks++;
    if (lat != 4) begin
      failures++;
      $display("FAIL bp_latency: got %0d cycles, want 4", lat);
    end
    e  = q_sat.pop_front();
    en = q_ns.pop_front();
    checks++;
    if (res_ns !== en.res || ovf_ns !== en.ovf) begin
      failures++;
      $display("FAIL bp_res_nosat: got %h/%b, want %h/%b", res_ns, ovf_ns, en.res, en.ovf);
    end
    a = 8'h55;
    b = 8'h66;
    in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (rdy !== 1'b0 || ov !== 1'b1 || res !== e.res || ovf !== e.ovf) begin
        failures++;
        $display("FAIL bp_hold[%0d]: in_ready=%b out_valid=%b res=%h ovf=%b, want 0 1 %h %b",
                 k, rdy, ov, res, ovf, e.res, e.ovf);
      end
      tick();
    end
    out_ready = 1'b1;
    push_main(8'h55, 8'h66);
    tick();
    checks++;
    if (rdy !== 1'b1 || ov !== 1'b0) begin
      failures++;
      $display("FAIL bp_after_handshake: in_ready=%b out_valid=%b, want 1 0", rdy, ov);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (rdy !== 1'b0) begin
      failures++;
      $display("FAIL bp_second_accept: in_ready=%b, want 0", rdy);
    end
    wait_out(1'b0, lat);
    checks++;
    if (lat != 4) begin
      failures++;
      $display("FAIL bp_second_latency: got %0d cycles, want 4", lat);
    end
    e  = q_sat.pop_front();
    en = q_ns.pop_front();
    checks++;
    if (res !== e.res || ovf !== e.ovf || res_ns !== en.res || ovf_ns !== en.ovf) begin
      failures++;
      $display("FAIL bp_second_res: got %h/%b %h/%b, want %h/%b %h/%b",
               res, ovf, res_ns, ovf_ns, e.res, e.ovf, en.res, en.ovf);
    end
    tick();
  endtask

  task automatic test_reset_abort();
    exp_t e;
    int   lat, seen;
    out_ready = 1'b1;
    send(8'h77, 8'h99);
    tick();
    tick();
    checks++;
    if (rdy !== 1'b0) begin
      failures++;
      $display("FAIL abort_in_calc: in_ready=%b, want 0", rdy);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (rdy !== 1'b1 || ov !== 1'b0) begin
      failures++;
      $display("FAIL abort_async: in_ready=%b out_valid=%b, want 1 0", rdy, ov);
    end
    tick();
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      if (ov !== 1'b0 || ov_ns !== 1'b0) seen++;
      tick();
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL abort_no_output: out_valid high in %0d cycles, want 0", seen);
    end
    q_sat.push_back('{16'h0006, 1'b0});
    q_ns.push_back('{16'h0006, 1'b0});
    send(8'h02, 8'h03);
    wait_out(1'b0, lat);
    e = q_sat.pop_front();
    void'(q_ns.pop_front());
    checks++;
    if (lat != 4 || res !== e.res || ovf !== e.ovf) begin
      failures++;
      $display("FAIL abort_fresh: lat=%0d res=%h ovf=%b, want 4 %h %b", lat, res, ovf, e.res, e.ovf);
    end
    tick();
  endtask

  task automatic test_overflow();
    exp_t e, en;
    int   lat;
    out_ready = 1'b1;
    q_sat.push_back('{16'hFFFF, 1'b1});
    q_ns.push_back('{16'h1011, 1'b1});
    send(8'hFF, 8'hFF);
    wait_out(1'b0, lat);
    e  = q_sat.pop_front();
    en = q_ns.pop_front();
    checks++;
    if (res !== e.res || ovf !== e.ovf) begin
      failures++;
      $display("FAIL ovf_sat: got %h/%b, want %h/%b", res, ovf, e.res, e.ovf);
    end
    checks++;
    if (res_ns !== en.res || ovf_ns !== en.ovf) begin
      failures++;
      $display("FAIL ovf_wrap: got %h/%b, want %h/%b", res_ns, ovf_ns, en.res, en.ovf);
    end
    tick();
  endtask

  task automatic test_random();
    exp_t       e, en;
    int         lat;
    logic [7:0] x, y;
    out_ready = 1'b1;
    for (int n = 0; n < 10000; n++) begin
      x = 8'($urandom_range(0, 255));
      y = 8'($urandom_range(0, 255));
      push_main(x, y);
      send(x, y);
      wait_out(1'b0, lat);
      e  = q_sat.pop_front();
      en = q_ns.pop_front();
      checks++;
      if (lat != 4) begin
        failures++;
        $display("FAIL rand_latency[%0d]: got %0d cycles, want 4", n, lat);
        break;
      end
      checks++;
      if (res !== e.res || ovf !== e.ovf) begin
        failures++;
        $display("FAIL rand_sat[%0d] a=%h b=%h: got %h/%b, want %h/%b", n, x, y, res, ovf, e.res, e.ovf);
      end
      checks++;
      if (res_ns !== en.res || ovf_ns !== en.ovf) begin
        failures++;
        $display("FAIL rand_wrap[%0d] a=%h b=%h: got %h/%b, want %h/%b",
                 n, x, y, res_ns, ovf_ns, en.res, en.ovf);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    exp_t e, en;
    int   last, rcnt, nres, cyc;
    bit   acc_now;
    out_ready = 1'b1;
    a = 8'($urandom_range(0, 255));
    b = 8'($urandom_range(0, 255));
    in_valid = 1'b1;
    last = -1;
    rcnt = 0;
    nres = 0;
    cyc  = 0;
    while (nres < 8 && cyc < 200) begin
      acc_now = rdy;
      if (rdy) begin
        push_main(a, b);
        rcnt++;
      end
      if (ov) begin
        e  = q_sat.pop_front();
        en = q_ns.pop_front();
        checks++;
        if (res !== e.res || ovf !== e.ovf || res_ns !== en.res || ovf_ns !== en.ovf) begin
          failures++;
          $display("FAIL b2b_res[%0d]: got %h/%b %h/%b, want %h/%b %h/%b",
                   nres, res, ovf, res_ns, ovf_ns, e.res, e.ovf, en.res, en.ovf);
        end
        // Each result occupies one IDLE accept, four CALC steps and one DONE cycle.
        if (last >= 0) begin
          checks++;
          if (cyc - last != 6) begin
            failures++;
            $display("FAIL b2b_period[%0d]: got %0d cycles, want 6", nres, cyc - last);
          end
        end
        checks++;
        if (rcnt != 1) begin
          failures++;
          $display("FAIL b2b_ready_pulses[%0d]: got %0d, want 1", nres, rcnt);
        end
        rcnt = 0;
        last = cyc;
        nres++;
      end
      tick();
      cyc++;
      if (acc_now) begin
        a = 8'($urandom_range(0, 255));
        b = 8'($urandom_range(0, 255));
      end
    end
    in_valid = 1'b0;
    checks++;
    if (nres != 8) begin
      failures++;
      $display("FAIL b2b_timeout: got %0d results, want 8", nres);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_trunc();
    test_backpressure();
    test_reset_abort();
    test_overflow();
    test_random();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
